vga_draw_scheduler: RTL and testbench

//  Sequences cell redraws into vga_display. Two requesters share one drawer: a user-edit queue
//  (single cell, explicit colour) and a playhead column sweep (12 cells, colour read from pattern

---
 rtl/vga_draw_scheduler.sv | 168 ++++++++++++++++
 tb/tb_vga_draw_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: arbitrates user edits and column sweeps into one-cell-at-a-time redraws for vga_display
module vga_draw_scheduler #(
    parameter int X0         = 214,
    parameter int Y0         = 32,
    parameter int PITCH      = 33,
    parameter int GRID       = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    input  logic [3:0] i_req_row,
    input  logic [3:0] i_req_col,
    input  logic       i_req_state,
    output logic       o_req_ready,
    input  logic       i_col_valid,
    input  logic [3:0] i_col_idx,
    output logic       o_col_ready,
    output logic [3:0] o_rd_row,
    output logic [3:0] o_rd_col,
    input  logic       i_rd_state,
    output logic       o_draw_enable,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_state,
    input  logic       i_drawing,
    output logic       o_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] L_GRID = 4'(GRID);
    localparam logic [3:0] L_LAST = 4'(GRID - 1);
    localparam logic [AW:0] L_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_BOOT_HI, S_BOOT_LO, S_IDLE, S_FETCH, S_LATCH,
        S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_GAP
    } state_t;

    state_t      r_fsm;
    logic [8:0]  r_fifo [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0] r_count;
    logic        r_sweep_active;
    logic        r_cur_sweep;
    logic [3:0]  r_sweep_row;
    logic [3:0]  r_sweep_col;
    logic        r_draw_enable;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        r_state;
    logic [3:0]  r_rd_row;
    logic [3:0]  r_rd_col;

    logic        w_boot;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_col_take;
    logic [8:0]  w_head;
    logic [3:0]  w_cell_row;
    logic [3:0]  w_cell_col;
    logic [9:0]  w_x;
    logic [8:0]  w_y;

    assign w_boot      = (r_fsm == S_BOOT_HI) || (r_fsm == S_BOOT_LO);
    assign w_empty     = (r_count == '0);
    assign o_req_ready = (r_count != L_FULL) && !w_boot;
    assign o_col_ready = !w_boot && !r_sweep_active;
    assign w_push      = i_req_valid && o_req_ready && (i_req_row < L_GRID) && (i_req_col < L_GRID);
    assign w_pop       = (r_fsm == S_IDLE) && !w_empty;
    assign w_col_take  = i_col_valid && o_col_ready;
    assign w_head      = r_fifo[r_rd_ptr];
    assign w_cell_row  = w_pop ? w_head[8:5] : r_sweep_row;
    assign w_cell_col  = w_pop ? w_head[4:1] : r_sweep_col;
    assign w_x         = 10'(X0) + 10'(PITCH) * {6'd0, w_cell_col};
    assign w_y         = 9'(Y0) + 9'(PITCH) * {5'd0, w_cell_row};
    assign o_busy      = w_boot || (r_fsm != S_IDLE) || !w_empty || r_sweep_active;

    assign o_draw_enable = r_draw_enable;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_state       = r_state;
    assign o_rd_row      = r_rd_row;
    assign o_rd_col      = r_rd_col;

    // edit queue storage: {row, col, colour}; contents are meaningless while count is zero
    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {i_req_row, i_req_col, i_req_state};
    end

    // edit queue pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

    // draw sequencer: boot handshake, edit-over-sweep arbitration, pattern fetch and display handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm          <= S_BOOT_HI;
            r_sweep_active <= 1'b0;
            r_cur_sweep    <= 1'b0;
            r_sweep_row    <= '0;
            r_sweep_col    <= '0;
            r_draw_enable  <= 1'b0;
            r_x            <= 10'(X0);
            r_y            <= 9'(Y0);
            r_state        <= 1'b0;
            r_rd_row       <= '0;
            r_rd_col       <= '0;
        end else begin
            r_draw_enable <= 1'b0;
            if (w_col_take && (i_col_idx < L_GRID)) begin
                r_sweep_active <= 1'b1;
                r_sweep_col    <= i_col_idx;
                r_sweep_row    <= '0;
            end
            case (r_fsm)
                S_BOOT_HI: if (i_drawing) r_fsm <= S_BOOT_LO;
                S_BOOT_LO: if (!i_drawing) r_fsm <= S_GAP;
                S_IDLE: begin
                    if (w_pop) begin
                        r_x           <= w_x;
                        r_y           <= w_y;
                        r_state       <= w_head[0];
                        r_cur_sweep   <= 1'b0;
                        r_draw_enable <= 1'b1;
                        r_fsm         <= S_ISSUE;
                    end else if (r_sweep_active) begin
                        r_rd_row <= r_sweep_row;
                        r_rd_col <= r_sweep_col;
                        r_fsm    <= S_FETCH;
                    end
                end
                S_FETCH: r_fsm <= S_LATCH;
                S_LATCH: begin
                    r_x           <= w_x;
                    r_y           <= w_y;
                    r_state       <= i_rd_state;
                    r_cur_sweep   <= 1'b1;
                    r_draw_enable <= 1'b1;
                    r_fsm         <= S_ISSUE;
                end
                S_ISSUE:   r_fsm <= S_WAIT_HI;
                S_WAIT_HI: if (i_drawing) r_fsm <= S_WAIT_LO;
                S_WAIT_LO: begin
                    if (!i_drawing) begin
                        if (r_cur_sweep) begin
                            if (r_sweep_row == L_LAST) r_sweep_active <= 1'b0;
                            else r_sweep_row <= r_sweep_row + 4'd1;
                        end
                        r_fsm <= S_GAP;
                    end
                end
                S_GAP:   r_fsm <= S_IDLE;
                default: r_fsm <= S_BOOT_HI;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb_vga_draw_scheduler: directed stimulus with a draw scoreboard popped by an independent monitor
module tb_vga_draw_scheduler;
    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       s;
    } exp_t;

    localparam int YT [12] = '{32, 65, 98, 131, 164, 197, 230, 263, 296, 329, 362, 395};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req_valid = 1'b0;
    logic [3:0] req_row = '0;
    logic [3:0] req_col = '0;
    logic req_state = 1'b0;
    logic col_valid = 1'b0;
    logic [3:0] col_idx = '0;
    logic force_en = 1'b1;
    logic force_val = 1'b0;
    logic r_auto = 1'b0;
    int r_cnt = 0;
    logic r_mem = 1'b0;
    logic drawing;

    logic req_ready, col_ready, draw_enable, st, busy;
    logic [3:0] rd_row, rd_col;
    logic [9:0] x;
    logic [8:0] y;

    exp_t sb[$];
    exp_t m_e;
    int errors = 0;
    int checks = 0;
    int n_draws = 0;
    int base, bad, t;
    bit pulsed;
    logic hold = 1'b0;
    logic seen_hi = 1'b0;
    logic hold_bad = 1'b0;
    logic [9:0] cx;
    logic [8:0] cy;
    logic cs;

    always #5 clk = ~clk;

    assign drawing = force_en ? force_val : r_auto;

    vga_draw_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_row(req_row), .i_req_col(req_col), .i_req_state(req_state),
        .o_req_ready(req_ready),
        .i_col_valid(col_valid), .i_col_idx(col_idx), .o_col_ready(col_ready),
        .o_rd_row(rd_row), .o_rd_col(rd_col), .i_rd_state(r_mem),
        .o_draw_enable(draw_enable), .o_x(x), .o_y(y), .o_state(st),
        .i_drawing(drawing), .o_busy(busy)
    );

    // pattern memory with one-cycle read latency: bit = row[0] for column 5, inverted elsewhere
    always @(posedge clk) r_mem <= rd_row[0] ^ (rd_col != 4'd5);

    // display model: drawing rises after each draw_enable and stays high for three cycles
    always @(posedge clk) begin
        if (r_cnt != 0) begin
            r_cnt <= r_cnt - 1;
            if (r_cnt == 1) r_auto <= 1'b0;
        end else if (draw_enable) begin
            r_auto <= 1'b1;
            r_cnt  <= 3;
        end
    end

    // monitor: pops the scoreboard on every draw pulse and checks X/Y/state hold until drawing falls
    always @(negedge clk) begin
        if (!rst_n) hold = 1'b0;
        else begin
            if (hold) begin
                if (x != cx || y != cy || st != cs) hold_bad = 1'b1;
                if (drawing) seen_hi = 1'b1;
                else if (seen_hi) begin
                    checks++;
                    if (hold_bad) begin
                        errors++;
                        $display("FAIL hold: x/y/state moved during draw, now x=%0d y=%0d s=%0d required x=%0d y=%0d s=%0d", x, y, st, cx, cy, cs);
                    end
                    hold = 1'b0;
                end
            end
            if (draw_enable) begin
                n_draws++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL draw: unexpected draw x=%0d y=%0d s=%0d, none required", x, y, st);
                end else begin
                    m_e = sb.pop_front();
                    if (x != m_e.x || y != m_e.y || st != m_e.s) begin
                        errors++;
                        $display("FAIL draw: got x=%0d y=%0d s=%0d required x=%0d y=%0d s=%0d", x, y, st, m_e.x, m_e.y, m_e.s);
                    end
                end
                hold = 1'b1;
                seen_hi = 1'b0;
                hold_bad = 1'b0;
                cx = x;
                cy = y;
                cs = st;
            end
        end
    end

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_push(int ex, int ey, int es);
        exp_t e;
        e.x = 10'(ex);
        e.y = 9'(ey);
        e.s = es[0];
        sb.push_back(e);
    endtask

    task automatic push_edit(int row, int col, int s, bit drawn, int ex, int ey);
        int w = 0;
        while (!req_ready && w < 200) begin
            cyc(1);
            w++;
        end
        check("edit_ready_wait", int'(req_ready), 1);
        if (drawn) exp_push(ex, ey, s);
        req_valid = 1'b1;
        req_row = 4'(row);
        req_col = 4'(col);
        req_state = s[0];
        cyc(1);
        req_valid = 1'b0;
    endtask

    task automatic sweep_req(int c);
        check("col_ready_before_sweep", int'(col_ready), 1);
        col_valid = 1'b1;
        col_idx = 4'(c);
        cyc(1);
        col_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 1000) begin
            cyc(1);
            w++;
        end
        check("idle_wait", int'(busy), 0);
    endtask

    task automatic wait_draws(int n);
        int w = 0;
        while (n_draws < n && w < 1000) begin
            cyc(1);
            w++;
        end
        check("draw_wait", int'(n_draws >= n), 1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_draw_enable"}, int'(draw_enable), 0);
        check({tag, "_x"}, int'(x), 214);
        check({tag, "_y"}, int'(y), 32);
        check({tag, "_state"}, int'(st), 0);
        check({tag, "_rd_row"}, int'(rd_row), 0);
        check({tag, "_rd_col"}, int'(rd_col), 0);
        check({tag, "_req_ready"}, int'(req_ready), 0);
        check({tag, "_col_ready"}, int'(col_ready), 0);
        check({tag, "_busy"}, int'(busy), 1);
    endtask

    task automatic boot();
        force_en = 1'b1;
        force_val = 1'b1;
        cyc(3);
        force_val = 1'b0;
        cyc(3);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        cyc(3);
        rst_n = 1'b1;
        cyc(10);
        check("boot_req_ready", int'(req_ready), 0);
        check("boot_no_draw", n_draws, 0);
        boot();
        check("post_boot_req_ready", int'(req_ready), 1);
        check("post_boot_col_ready", int'(col_ready), 1);
        check("post_boot_busy", int'(busy), 0);
        force_en = 1'b0;

        push_edit(2, 3, 1, 1'b1, 313, 98);
        wait_idle();
        check("single_edit_draws", n_draws, 1);

        force_en = 1'b1;
        force_val = 1'b1;
        push_edit(0, 0, 0, 1'b1, 214, 32);
        cyc(4);
        for (int i = 0; i < 5; i++) begin
            check("fifo_ready", int'(req_ready), int'(i < 4));
            req_valid = 1'b1;
            case (i)
                0: begin req_row = 4'd11; req_col = 4'd11; req_state = 1'b1; exp_push(577, 395, 1); end
                1: begin req_row = 4'd1;  req_col = 4'd0;  req_state = 1'b1; exp_push(214, 65, 1); end
                2: begin req_row = 4'd0;  req_col = 4'd1;  req_state = 1'b0; exp_push(247, 32, 0); end
                3: begin req_row = 4'd5;  req_col = 4'd7;  req_state = 1'b1; exp_push(445, 197, 1); end
                default: begin req_row = 4'd9; req_col = 4'd9; req_state = 1'b1; end
            endcase
            cyc(1);
        end
        req_valid = 1'b0;
        cyc(3);
        force_en = 1'b0;
        wait_idle();
        check("fifo_drain_draws", n_draws, 6);

        base = n_draws;
        for (int r = 0; r < 12; r++) exp_push(379, YT[r], r & 1);
        sweep_req(5);
        bad = 0;
        t = 0;
        pulsed = 1'b0;
        while (n_draws < base + 12 && t < 2000) begin
            if (col_ready) bad++;
            if (!pulsed && n_draws >= base + 3) begin
                col_valid = 1'b1;
                col_idx = 4'd2;
                pulsed = 1'b1;
            end else col_valid = 1'b0;
            cyc(1);
            t++;
        end
        col_valid = 1'b0;
        check("sweep_col_ready_low_cycles", bad, 0);
        check("sweep_draws_reached", int'(n_draws >= base + 12), 1);
        wait_idle();
        check("sweep_draws", n_draws, base + 12);

        base = n_draws;
        for (int r = 0; r < 5; r++) exp_push(379, YT[r], r & 1);
        sweep_req(5);
        wait_draws(base + 5);
        push_edit(6, 6, 1, 1'b1, 412, 230);
        for (int r = 5; r < 12; r++) exp_push(379, YT[r], r & 1);
        wait_idle();
        check("interleave_draws", n_draws, base + 13);
        push_edit(12, 0, 1, 1'b0, 0, 0);
        push_edit(0, 12, 1, 1'b0, 0, 0);
        sweep_req(12);
        cyc(6);
        check("out_of_range_busy", int'(busy), 0);
        check("out_of_range_draws", n_draws, base + 13);

        base = n_draws;
        force_en = 1'b1;
        force_val = 1'b1;
        push_edit(3, 4, 0, 1'b1, 346, 131);
        cyc(4);
        check("pre_reset_draws", n_draws, base + 1);
        push_edit(1, 1, 1, 1'b0, 0, 0);
        cyc(2);
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        force_val = 1'b0;
        rst_n = 1'b1;
        cyc(5);
        check("midreset_boot_req_ready", int'(req_ready), 0);
        boot();
        force_en = 1'b0;
        cyc(6);
        check("midreset_fifo_cleared_busy", int'(busy), 0);
        check("midreset_no_draws", n_draws, base + 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
